piarb_flow_sched: RTL
=====================

Name: piarb_flow_sched

Overview:
Per-packet flow-affinity scheduler in front of the PU-input flow-ID TCAM. For each requested packet FID it runs one TCAM lookup. On a hit, the packet is steered to the PU/slot already holding that FID, which preserves per-flow ordering. On a miss, it allocates a free PU flow slot round-robin, writes the FID into the TCAM, and issues the enqueue. It sits between the packet-descriptor front end and the TCAM/PU queue logic.

Parameters:
ID_NBITS, `PU_ID_NBITS, PU index width
QUEUE_DEPTH, `NUM_OF_PU, number of PUs (TCAM rows)
FID_NBITS, `FID_NBITS, flow ID width
STALL_CNT_NBITS, 16, stall statistics counter width

Ports:
clk  in  1  clock
rst  in  1  reset (`RESET_SIG)
sch_req  in  1  packet needs scheduling; held until sch_gnt
sch_fid  in  FID_NBITS  packet flow ID; stable while sch_req
sch_gnt  out  1  one-cycle grant pulse
sch_qid  out  ID_NBITS  chosen PU, valid with sch_gnt
sch_fid_sel  out  1  chosen slot (0/1), valid with sch_gnt
pu_queue_full  in  QUEUE_DEPTH  per-PU queue full
fid_lookup_req  out  1  TCAM lookup pulse
fid_lookup_fid  out  FID_NBITS  lookup key
fid_lookup_ack  in  1  lookup result valid
fid_lookup_fid_valid  in  [1:0] x QUEUE_DEPTH  per-PU slot occupied
fid_lookup_fid_hit  in  [1:0] x QUEUE_DEPTH  per-PU slot match
wr_fid_req  out  1  TCAM FID write pulse
wr_fid  out  FID_NBITS  FID to write
wr_fid_sel_id  out  ID_NBITS  PU row to write; zero-extended at integration
wr_fid_sel  out  1  slot to write
enq_req  out  1  enqueue pulse (increments slot count)
enq_qid  out  ID_NBITS  enqueue PU
enq_fid_sel  out  1  enqueue slot
stall_cnt  out  STALL_CNT_NBITS  saturating retry count
multi_hit_err  out  1  sticky: more than one hit seen

Behaviour:
- Clocking and reset: single clock clk. rst is synchronous, active-high.
- Reset values: all outputs 0. State IDLE. rr_ptr=0. stall_cnt=0. multi_hit_err=0.
- FSM states: IDLE, LOOKUP, WAIT, ISSUE.
- IDLE: if sch_req, go to LOOKUP and latch sch_fid.
- LOOKUP (1 cycle): fid_lookup_req=1, fid_lookup_fid=latched FID. Always go to WAIT.
- WAIT: hold until fid_lookup_ack. On ack, decide from the same-cycle valid/hit vectors and pu_queue_full, then register the decision.
  - Hit rule: choose the lowest PU index with any hit bit; within a PU, slot 0 beats slot 1.
  - Hit and that PU not full: go to ISSUE with new=0.
  - Hit and that PU full: retry.
  - More than one hit bit set: set multi_hit_err and still take the lowest.
  - Miss rule: search PUs starting at rr_ptr and wrapping modulo QUEUE_DEPTH. Take the first PU that has a slot with valid=0 and pu_queue_full=0; slot 0 is preferred. Go to ISSUE with new=1.
  - Miss and no free slot: retry.
  - Retry: go to LOOKUP and increment stall_cnt, saturating at all-ones.
- ISSUE (1 cycle): sch_gnt=1 and enq_req=1, with qid/sel driven on the sch_* and enq_* ports.
  - If new: also wr_fid_req=1 with wr_fid=latched FID and the same id/sel.
  - If new: rr_ptr <= (chosen PU+1) mod QUEUE_DEPTH, wrapping from QUEUE_DEPTH-1 to 0. rr_ptr is unchanged on a hit.
  - Then go to IDLE.
- Latency: sch_req seen in cycle 0, lookup in cycle 1, ack in cycle 2 (TCAM registered, 1 cycle), grant in cycle 3, back to IDLE in cycle 4. Minimum 4 cycles per packet, no overlap.
  - The no-overlap rule guarantees the slot count and FID are updated before the next lookup.
- sch_req falling before sch_gnt is a protocol error. Behaviour in that case is undefined; the bench must not do it.
- A lookup_ack while not in WAIT is ignored.
- Reset in any state aborts immediately: no enq_req or wr_fid_req is emitted afterwards.

Decomposition:
- piarb_pkg holds the state enum (IDLE/LOOKUP/WAIT/ISSUE) and the slot-select typedef {qid, sel, new}.
- Sub-module piarb_rr_find: combinational rotating first-one finder over a QUEUE_DEPTH candidate vector starting at rr_ptr. Returns found flag and index. Instantiated once for free-slot search.
- Hit selection uses a plain lowest-index priority encoder inline.

Test Plan (QUEUE_DEPTH=4):
- Empty TCAM, reset, sch_fid=0x12: lookup_req in cycle 1 with fid 0x12. Cycle 3: wr_fid_req (0x12, id 0, sel 0), enq_req qid 0 sel 0, sch_gnt. rr_ptr becomes 1.
- Hit: valid[2]=2'b10, hit[2]=2'b10: grant qid 2 sel 1, wr_fid_req stays 0, rr_ptr unchanged.
- Hit with pu_queue_full[2]=1 for 2 lookups: lookups repeat at cycles 1, 4, 7; grant follows the third lookup; stall_cnt=2.
- Wrap: rr_ptr=3, PU3 full, PU0 slot 0 free: allocate qid 0 sel 0, rr_ptr becomes 1. All 8 slots valid with no hit: retries until a valid bit clears.
- Multi-hit: hit[1]=2'b01 and hit[3]=2'b10: grant qid 1 sel 0; multi_hit_err=1 and it stays set until rst.
- rst asserted in WAIT: no enq_req, wr_fid_req or sch_gnt in any following cycle; all outputs 0; next request starts from rr_ptr=0.

Source files
------------

// File: rtl/piarb_pkg.sv
// Shared types for the flow-affinity scheduler: FSM state and the registered slot decision.
package piarb_pkg;

    localparam int PIARB_ID_NBITS = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WAIT,
        ST_ISSUE
    } state_e;

    typedef struct packed {
        logic [PIARB_ID_NBITS-1:0] qid;
        logic                      sel;
        logic                      is_new;
    } slot_sel_t;

endpackage

// File: rtl/piarb_rr_find.sv
// Rotating first-one finder: lowest set candidate at or after start_i, wrapping modulo N.
module piarb_rr_find #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  cand_i,
    input  logic [IW-1:0] start_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    int unsigned p;

    // Walk offsets high to low so the smallest offset from start_i wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        p       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            p = int'(start_i) + k;
            if (p >= N) p = p - N;
            if (cand_i[p]) begin
                found_o = 1'b1;
                idx_o   = IW'(p);
            end
        end
    end

endmodule

// File: rtl/piarb_flow_sched.sv
// Flow-affinity scheduler: one TCAM lookup per packet, steer hits to the owning PU slot,
// allocate misses round-robin. Retries pass through ISSUE without a grant, giving a 3-cycle lookup period.
module piarb_flow_sched
    import piarb_pkg::*;
#(
    parameter int ID_NBITS        = PIARB_ID_NBITS,
    parameter int QUEUE_DEPTH     = 4,
    parameter int FID_NBITS       = 8,
    parameter int STALL_CNT_NBITS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sch_req,
    input  logic [FID_NBITS-1:0]       sch_fid,
    output logic                       sch_gnt,
    output logic [ID_NBITS-1:0]        sch_qid,
    output logic                       sch_fid_sel,
    input  logic [QUEUE_DEPTH-1:0]     pu_queue_full,
    output logic                       fid_lookup_req,
    output logic [FID_NBITS-1:0]       fid_lookup_fid,
    input  logic                       fid_lookup_ack,
    input  logic [2*QUEUE_DEPTH-1:0]   fid_lookup_fid_valid,
    input  logic [2*QUEUE_DEPTH-1:0]   fid_lookup_fid_hit,
    output logic                       wr_fid_req,
    output logic [FID_NBITS-1:0]       wr_fid,
    output logic [ID_NBITS-1:0]        wr_fid_sel_id,
    output logic                       wr_fid_sel,
    output logic                       enq_req,
    output logic [ID_NBITS-1:0]        enq_qid,
    output logic                       enq_fid_sel,
    output logic [STALL_CNT_NBITS-1:0] stall_cnt,
    output logic                       multi_hit_err
);

    state_e                 state_q;
    logic [ID_NBITS-1:0]    rr_q;
    logic                   retry_q;

    logic [QUEUE_DEPTH-1:0] free_cand;
    logic                   free_found;
    logic [ID_NBITS-1:0]    free_qid;
    logic                   hit_any;
    logic [ID_NBITS-1:0]    hit_qid;
    logic                   hit_sel;
    logic                   multi_hit;
    slot_sel_t              pick;
    logic                   pick_ok;

    // A PU can take a new flow if its queue has room and at least one slot is empty.
    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            free_cand[i] = !pu_queue_full[i] &&
                           !(fid_lookup_fid_valid[2*i] && fid_lookup_fid_valid[2*i+1]);
        end
    end

    piarb_rr_find #(
        .N  (QUEUE_DEPTH),
        .IW (ID_NBITS)
    ) u_free_find (
        .cand_i  (free_cand),
        .start_i (rr_q),
        .found_o (free_found),
        .idx_o   (free_qid)
    );

    always_comb begin
        hit_any = 1'b0;
        hit_qid = '0;
        hit_sel = 1'b0;
        for (int i = 2*QUEUE_DEPTH - 1; i >= 0; i--) begin
            if (fid_lookup_fid_hit[i]) begin
                hit_any = 1'b1;
                hit_qid = ID_NBITS'(i / 2);
                hit_sel = i[0];
            end
        end
    end

    assign multi_hit = $countones(fid_lookup_fid_hit) > 1;

    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        if (hit_any) begin
            pick.qid    = PIARB_ID_NBITS'(hit_qid);
            pick.sel    = hit_sel;
            pick_ok     = !pu_queue_full[hit_qid];
        end else if (free_found) begin
            pick.qid    = PIARB_ID_NBITS'(free_qid);
            pick.sel    = fid_lookup_fid_valid[{free_qid, 1'b0}];
            pick.is_new = 1'b1;
            pick_ok     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            rr_q           <= '0;
            retry_q        <= 1'b0;
            sch_gnt        <= 1'b0;
            sch_qid        <= '0;
            sch_fid_sel    <= 1'b0;
            fid_lookup_req <= 1'b0;
            fid_lookup_fid <= '0;
            wr_fid_req     <= 1'b0;
            wr_fid         <= '0;
            wr_fid_sel_id  <= '0;
            wr_fid_sel     <= 1'b0;
            enq_req        <= 1'b0;
            enq_qid        <= '0;
            enq_fid_sel    <= 1'b0;
            stall_cnt      <= '0;
            multi_hit_err  <= 1'b0;
        end else begin
            fid_lookup_req <= 1'b0;
            sch_gnt        <= 1'b0;
            enq_req        <= 1'b0;
            wr_fid_req     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sch_req) begin
                        fid_lookup_fid <= sch_fid;
                        fid_lookup_req <= 1'b1;
                        state_q        <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (fid_lookup_ack) begin
                        if (multi_hit) multi_hit_err <= 1'b1;
                        state_q <= ST_ISSUE;
                        retry_q <= !pick_ok;
                        if (pick_ok) begin
                            sch_gnt     <= 1'b1;
                            enq_req     <= 1'b1;
                            sch_qid     <= ID_NBITS'(pick.qid);
                            enq_qid     <= ID_NBITS'(pick.qid);
                            sch_fid_sel <= pick.sel;
                            enq_fid_sel <= pick.sel;
                            if (pick.is_new) begin
                                wr_fid_req    <= 1'b1;
                                wr_fid        <= fid_lookup_fid;
                                wr_fid_sel_id <= ID_NBITS'(pick.qid);
                                wr_fid_sel    <= pick.sel;
                                rr_q <= (ID_NBITS'(pick.qid) == ID_NBITS'(QUEUE_DEPTH - 1)) ?
                                        '0 : ID_NBITS'(pick.qid) + 1'b1;
                            end
                        end else if (stall_cnt != '1) begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (retry_q) begin
                        fid_lookup_req <= 1'b1;
                        state_q        <= ST_LOOKUP;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
